// File: rtl/mips_pkg.sv
// Shared ALU control codes, aluop encodings and R-type funct codes.
package mips_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_UNDEF = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;

  // True when a decoded ALU code means "no defined operation".
  function automatic logic is_undef(input logic [3:0] code);
    return code == ALU_UNDEF;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational aluop/funct decode into the 4-bit ALU control code.
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] control
);

  // Map the main-decoder aluop (and funct for R-type) to an ALU code.
  always_comb begin
    control = ALU_UNDEF;
    case (aluop_e'(aluop))
      ALUOP_ADD: control = ALU_ADD;
      ALUOP_SUB: control = ALU_SUB;
      ALUOP_RTYPE: begin
        if (funct == FUNCT_ADD) begin
          control = ALU_ADD;
        end else if (funct == FUNCT_SUB) begin
          control = ALU_SUB;
        end else begin
          control = ALU_UNDEF;
        end
      end
      default: control = ALU_UNDEF;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register as a two-entry elastic buffer (main + skid).
// Operand muxing and ALU control decode happen on the way in, so the
// held entry is already in the form the ALU consumes.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] input2,
  output logic [3:0]       control,
  output logic [RW-1:0]    out_rd,
  output logic             out_reg_write
);

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       ctl;
    logic [RW-1:0]    rd;
    logic             reg_write;
  } entry_t;

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic [3:0] dec_control;
  logic   accept;
  logic   pop;

  alu_ctrl u_alu_ctrl (
    .aluop   (in_aluop),
    .funct   (in_funct),
    .control (dec_control)
  );

  // in_ready depends only on flop state, so out_ready never reaches it.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  assign out_valid     = main_valid_q;
  assign input1        = main_q.op1;
  assign input2        = main_q.op2;
  assign control       = main_q.ctl;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;

  // Build the incoming entry; an undefined op must never write a register.
  always_comb begin
    in_entry.op1       = in_rs_val;
    in_entry.op2       = in_alusrc ? in_imm : in_rt_val;
    in_entry.ctl       = dec_control;
    in_entry.rd        = in_rd;
    in_entry.reg_write = in_reg_write && !is_undef(dec_control);
  end

  // Next-state of both entries: pop first, then place any accepted entry.
  // Skid can only be full while in_ready is low, so a pop that refills
  // main from skid never coincides with an accept.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    if (accept) begin
      if (!main_valid_q || pop) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over everything and zeroes the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width.
REQ-002 SHALL have parameter RW, default 5, the register-index width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  discards all held entries (branch/exception squash).
REQ-006 SHALL have port in_valid  in  1  ID offers a decoded instruction.
REQ-007 SHALL have port in_ready  out  1  stage can accept this cycle.
REQ-008 SHALL have port in_rs_val, in_rt_val, in_imm  in  WIDTH each  register operands and sign-extended immediate.
REQ-009 SHALL have port in_alusrc  in  1  1 selects in_imm as second operand, 0 selects in_rt_val.
REQ-010 SHALL have port in_aluop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 reserved.
REQ-011 SHALL have port in_funct  in  6  R-type function field.
REQ-012 SHALL have ports in_rd  in  RW  and  in_reg_write  in  1  destination index and write enable.
REQ-013 SHALL have port out_valid  out  1  held entry presented to ALU.
REQ-014 SHALL have port out_ready  in  1  EX/MEM side accepts the presented entry.
REQ-015 SHALL have ports input1, input2  out  WIDTH  and  control  out  4  ALU operands and ALU control code.
REQ-016 SHALL have ports out_rd  out  RW  and  out_reg_write  out  1.

Function
REQ-017 SHALL be a two-entry elastic stage (main + skid); outputs SHALL always come from main.
REQ-018 SHALL assert in_ready iff skid is empty (registered, no combinational path from out_ready).
REQ-019 SHALL accept on in_valid && in_ready, pop on out_valid && out_ready; latency empty-to-out_valid = 1 cycle; throughput 1/cycle.
REQ-020 SHALL load an accepted entry into main if main is empty or popping this cycle, else into skid.
REQ-021 SHALL move skid into main on pop when skid is full; simultaneous accept in that cycle is impossible (in_ready low).
REQ-022 SHALL hold main and all outputs stable while out_valid && !out_ready.
REQ-023 SHALL compute at capture: input1 = in_rs_val; input2 = in_alusrc ? in_imm : in_rt_val.
REQ-024 SHALL decode control at capture: aluop 00 -> 0010; 01 -> 0110; 10 with funct 100000 -> 0010; 10 with funct 100010 -> 0110; all other combinations -> 1111 (undefined; ALU yields 0).
REQ-025 SHALL force out_reg_write to 0 for any entry decoded to 1111.
REQ-026 SHALL, on flush, empty both entries next cycle; flush SHALL take priority over a same-cycle accept (input dropped) and pop.
REQ-027 SHALL assert in_ready the cycle after flush.
REQ-028 SHALL never drop or duplicate an entry absent flush/reset; order SHALL be FIFO.

Reset
REQ-029 SHALL, on reset, clear main and skid valid; out_valid=0, in_ready=1 the following cycle.
REQ-030 SHALL reset input1=0, input2=0, control=0000, out_rd=0, out_reg_write=0.
REQ-031 SHALL let reset override flush, accept and pop in the same cycle, including mid-stall.

Structure
REQ-032 SHALL take ALU codes (ADD 0010, SUB 0110, UNDEF 1111), aluop encodings and funct codes from shared package mips_pkg.
REQ-033 SHALL place the aluop/funct decode in combinational sub-module alu_ctrl, instantiated once on the input side.

Verification
REQ-034 Single accept: rs=5, rt=3, alusrc=0, aluop=10, funct=100010, out_ready=1 -> next cycle out_valid=1, input1=5, input2=3, control=0110.
REQ-035 Immediate path: rs=0x10, imm=0xFFFFFFFC, alusrc=1, aluop=00 -> input2=0xFFFFFFFC, control=0010.
REQ-036 Backpressure: out_ready=0, three back-to-back offers A,B,C -> A held on outputs, B in skid, in_ready=0 on C; release out_ready -> A,B,C emerge in order, none lost.
REQ-037 Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; offered entry not seen on output.
REQ-038 Undefined op: aluop=10, funct=100100, reg_write=1 -> control=1111, out_reg_write=0.
REQ-039 Reset while stalled with both entries full -> next cycle out_valid=0, in_ready=1, all outputs zero.
